// File: rtl/core_lsu.sv
// core_lsu: load/store unit behind core_alu. Runs one data-memory
// transaction at a time over a req/ack bus. Loads return extracted and
// extended data to writeback. Misaligned, illegal and timed-out accesses
// raise a one-cycle exception pulse.
module core_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        i_lb,
  input  logic        i_lh,
  input  logic        i_lw,
  input  logic        i_lbu,
  input  logic        i_lhu,
  input  logic        i_sb,
  input  logic        i_sh,
  input  logic        i_sw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr
);

  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [7:0]  op_s;          // {lb, lh, lw, lbu, lhu, sb, sh, sw}
  logic [4:0]  ld_r;          // latched load flags {lb, lh, lw, lbu, lhu}
  logic [31:0] addr_r;
  logic [4:0]  rd_r;
  logic [7:0]  cnt_r;
  logic        accept_s, onehot_s, misaligned_s, is_store_s;
  logic        exc_s, load_done_s;
  logic [1:0]  exc_code_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Select the byte/halfword lane and extend it according to the load type.
  function automatic logic [31:0] load_extract(input logic [4:0] ld,
                                               input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    if (ld[4])      return {{24{b[7]}}, b};
    else if (ld[3]) return {{16{h[15]}}, h};
    else if (ld[1]) return {24'd0, b};
    else if (ld[0]) return {16'd0, h};
    else if (ld[2]) return d;
    else            return 32'd0;
  endfunction

  assign op_s     = {i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw};
  assign accept_s = in_valid & in_ready;

  // Decode the incoming request: legality, alignment and store lane formatting.
  always_comb begin
    onehot_s     = is_onehot(op_s);
    misaligned_s = ((op_s[6] | op_s[3] | op_s[1]) & addr[0]) |
                   ((op_s[5] | op_s[0]) & (addr[1:0] != 2'b00));
    is_store_s   = |op_s[2:0];
    if (op_s[2]) begin
      be_s    = 4'b0001 << addr[1:0];
      wdata_s = {4{wdata[7:0]}};
    end else if (op_s[1]) begin
      be_s    = 4'b0011 << addr[1:0];
      wdata_s = {2{wdata[15:0]}};
    end else begin
      be_s    = 4'b1111;
      wdata_s = wdata;
    end
  end

  // Next-state logic and selection of the outcome reported in DONE.
  always_comb begin
    state_s     = state_r;
    exc_s       = 1'b0;
    exc_code_s  = 2'b00;
    load_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (!onehot_s) begin
            state_s    = DONE;
            exc_s      = 1'b1;
            exc_code_s = 2'b11;
          end else if (misaligned_s) begin
            state_s    = DONE;
            exc_s      = 1'b1;
            exc_code_s = 2'b01;
          end else begin
            state_s = ACCESS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        // An ack in the final timeout cycle still completes the access.
        if (mem_ack) begin
          state_s     = DONE;
          load_done_s = |ld_r;
        end else if (cnt_r == CNT_LAST) begin
          state_s    = DONE;
          exc_s      = 1'b1;
          exc_code_s = 2'b10;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Latched request fields and the ack-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_r   <= 5'd0;
      addr_r <= 32'd0;
      rd_r   <= 5'd0;
      cnt_r  <= 8'd0;
    end else begin
      if (accept_s) begin
        ld_r   <= op_s[7:3];
        addr_r <= addr;
        rd_r   <= rd;
      end
      if ((state_r == ACCESS) && (state_s == ACCESS)) cnt_r <= cnt_r + 8'd1;
      else                                             cnt_r <= 8'd0;
    end
  end

  // Handshake and memory-bus outputs; bus fields are loaded once per access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      in_ready <= (state_s == IDLE);
      mem_req  <= (state_s == ACCESS);
      if ((state_r == IDLE) && (state_s == ACCESS)) begin
        mem_we    <= is_store_s;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be_s;
        mem_wdata <= wdata_s;
      end
    end
  end

  // Writeback and exception pulses; their payloads hold until the next pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      exc_valid <= 1'b0;
      exc_code  <= 2'b00;
      exc_addr  <= 32'd0;
    end else begin
      wb_valid  <= load_done_s;
      exc_valid <= exc_s;
      if (load_done_s) begin
        wb_rd   <= rd_r;
        wb_data <= load_extract(ld_r, addr_r[1:0], mem_rdata);
      end
      if (exc_s) begin
        exc_code <= exc_code_s;
        exc_addr <= (state_r == IDLE) ? addr : addr_r;
      end
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: expected writeback/exception results
// are queued when a request is driven and compared when the DUT pulses.
module tb_core_lsu;

  localparam int TIMEOUT = 16;
  localparam logic [7:0] F_LB  = 8'h80, F_LH  = 8'h40, F_LW = 8'h20, F_LBU = 8'h10;
  localparam logic [7:0] F_LHU = 8'h08, F_SB  = 8'h04, F_SH = 8'h02, F_SW  = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  flags;
  logic [31:0] addr, wdata, mem_addr, mem_wdata, mem_rdata, wb_data, exc_addr;
  logic [4:0]  rd, wb_rd;
  logic        mem_req, mem_we, mem_ack, wb_valid, exc_valid;
  logic [3:0]  mem_be;
  logic [1:0]  exc_code;

  typedef struct packed {
    logic        is_exc;
    logic [4:0]  tag;    // wb_rd for loads, exc_code for exceptions
    logic [31:0] val;    // wb_data for loads
    logic [31:0] eaddr;  // exc_addr for exceptions
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  core_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i_lb(flags[7]), .i_lh(flags[6]), .i_lw(flags[5]), .i_lbu(flags[4]),
    .i_lhu(flags[3]), .i_sb(flags[2]), .i_sh(flags[1]), .i_sw(flags[0]),
    .addr(addr), .wdata(wdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (wb_valid || exc_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(wb_valid | exc_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 32'(exc_valid), 32'(mon_e.is_exc));
        check("pulse_both", 32'(wb_valid & exc_valid), 32'd0);
        if (mon_e.is_exc) begin
          check("exc_code", 32'(exc_code), 32'(mon_e.tag));
          check("exc_addr", exc_addr, mon_e.eaddr);
        end else begin
          check("wb_rd", 32'(wb_rd), 32'(mon_e.tag));
          check("wb_data", wb_data, mon_e.val);
        end
      end
    end
  end

  // kind: 0 store, 1 load (val = wb data), 2 exception (val = exc code).
  // waits >= TIMEOUT means the memory never acknowledges.
  task automatic run_op(input logic [7:0] fl, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] r, input int waits, input logic [31:0] rdd,
                        input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input int kind, input logic [31:0] val);
    int   n;
    int   exp_n;
    exp_t e;
    if (kind == 2 && val != 32'd2) exp_n = 0;
    else                           exp_n = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
    if (kind != 0) begin
      e.is_exc = (kind == 2);
      e.tag    = (kind == 2) ? val[4:0] : r;
      e.val    = val;
      e.eaddr  = a;
      exp_q.push_back(e);
    end
    check("in_ready_pre", 32'(in_ready), 32'd1);
    flags = fl; addr = a; wdata = wd; rd = r; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flags = 8'd0;
    n = 0;
    while (mem_req === 1'b1 && n < 3 * TIMEOUT) begin
      check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      check("mem_we", 32'(mem_we), 32'(exp_we));
      check("mem_be", 32'(mem_be), 32'(exp_be));
      if (exp_we) check("mem_wdata", mem_wdata, exp_wd);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      if (n == waits) begin
        mem_ack = 1'b1; mem_rdata = rdd;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom();
      n++;
    end
    check("req_cycles", 32'(n), 32'(exp_n));
    check("wb_valid_done", 32'(wb_valid), 32'(kind == 1));
    check("exc_valid_done", 32'(exc_valid), 32'(kind == 2));
    @(negedge clk);
    check("in_ready_post", 32'(in_ready), 32'd1);
    check("pulse_one_cycle", 32'(wb_valid | exc_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flags = 8'd0; addr = 32'd0; wdata = 32'd0;
    rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_exc_valid", 32'(exc_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Loads: lane extraction and extension.
    run_op(F_LW,  32'h0000_0100, 32'd0, 5'd5, 0, 32'h1234_5678, 1'b0, 4'hF, 32'd0, 1, 32'h1234_5678);
    run_op(F_LB,  32'h0000_0007, 32'd0, 5'd6, 0, 32'h80AA_BBCC, 1'b0, 4'hF, 32'd0, 1, 32'hFFFF_FF80);
    run_op(F_LBU, 32'h0000_0007, 32'd0, 5'd7, 1, 32'h80AA_BBCC, 1'b0, 4'hF, 32'd0, 1, 32'h0000_0080);
    run_op(F_LHU, 32'h0000_0006, 32'd0, 5'd8, 0, 32'h80AA_BBCC, 1'b0, 4'hF, 32'd0, 1, 32'h0000_80AA);
    run_op(F_LH,  32'h0000_0006, 32'd0, 5'd9, 2, 32'h80AA_BBCC, 1'b0, 4'hF, 32'd0, 1, 32'hFFFF_80AA);
    run_op(F_LB,  32'h0000_0011, 32'd0, 5'd10, 0, 32'h80AA_BBCC, 1'b0, 4'hF, 32'd0, 1, 32'hFFFF_FFBB);
    run_op(F_LH,  32'h0000_0010, 32'd0, 5'd11, 0, 32'h1234_7FFE, 1'b0, 4'hF, 32'd0, 1, 32'h0000_7FFE);
    run_op(F_LW,  32'h0000_0020, 32'd0, 5'd0, 0, 32'hCAFE_F00D, 1'b0, 4'hF, 32'd0, 1, 32'hCAFE_F00D);

    // Stores: byte enables, lane replication, no writeback pulse.
    run_op(F_SB, 32'h0000_0005, 32'h0000_00AB, 5'd1, 3, 32'd0, 1'b1, 4'b0010, 32'hABAB_ABAB, 0, 32'd0);
    run_op(F_SH, 32'h0000_0006, 32'h1234_CDEF, 5'd1, 0, 32'd0, 1'b1, 4'b1100, 32'hCDEF_CDEF, 0, 32'd0);
    run_op(F_SW, 32'h0000_0008, 32'hDEAD_BEEF, 5'd1, 1, 32'd0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 0, 32'd0);

    // Misaligned and illegal requests never reach the bus.
    run_op(F_SW,  32'h0000_0007, 32'h1, 5'd1, 0, 32'd0, 1'b0, 4'h0, 32'd0, 2, 32'd1);
    run_op(F_LH,  32'h0000_0003, 32'h0, 5'd2, 0, 32'd0, 1'b0, 4'h0, 32'd0, 2, 32'd1);
    run_op(F_LW,  32'h0000_0102, 32'h0, 5'd2, 0, 32'd0, 1'b0, 4'h0, 32'd0, 2, 32'd1);
    run_op(F_LW | F_SW, 32'h0000_0040, 32'h0, 5'd3, 0, 32'd0, 1'b0, 4'h0, 32'd0, 2, 32'd3);
    run_op(8'h00, 32'h0000_0044, 32'h0, 5'd3, 0, 32'd0, 1'b0, 4'h0, 32'd0, 2, 32'd3);

    // Bus timeout, then an ack on the very last allowed cycle.
    run_op(F_LW, 32'h0000_0300, 32'h0, 5'd4, 99, 32'd0, 1'b0, 4'hF, 32'd0, 2, 32'd2);
    run_op(F_LW, 32'h0000_0304, 32'h0, 5'd4, TIMEOUT - 1, 32'h5555_AAAA, 1'b0, 4'hF, 32'd0, 1, 32'h5555_AAAA);

    // Asynchronous reset in the middle of an access.
    flags = F_LW; addr = 32'h0000_0200; rd = 5'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flags = 8'd0;
    check("rst_pre_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_req", 32'(mem_req), 32'd0);
    check("rst_async_ready", 32'(in_ready), 32'd1);
    check("rst_async_wb", 32'(wb_valid | exc_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;   // stray ack while idle must be ignored
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_req", 32'(mem_req), 32'd0);
    check("idle_ack_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    run_op(F_LW, 32'h0000_0200, 32'h0, 5'd3, 0, 32'h0BAD_F00D, 1'b0, 4'hF, 32'd0, 1, 32'h0BAD_F00D);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
